// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner: 32-step shift-add multiply / restoring divide beside EX. Result commits WIDTH+1 cycles after Start.
// Start while Busy is ignored and Stall holds EX. Optional MADD/MSUB accumulate under `define HILO_MACC_EN.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiLoRead,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, opd_q, acc_hi, acc_lo;
  logic             neg_res, neg_rem, b_zero;

  logic             is_mul, is_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_sub;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
`ifdef HILO_MACC_EN
    is_mul = (Op[2:1] == 2'b00) | (Op[2:1] == 2'b11);
`else
    is_mul = (Op[2:1] == 2'b00);
`endif
    is_div    = (Op[2:1] == 2'b01);
    op_signed = Op[2] ? Op[1] : ~Op[0];
    a_neg     = op_signed & OperandA[WIDTH-1];
    b_neg     = op_signed & OperandB[WIDTH-1];
    a_mag     = a_neg ? -OperandA : OperandA;
    b_mag     = b_neg ? -OperandB : OperandB;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Start && is_mul)      state_nxt = S_MUL;
        else if (Start && is_div) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == CW'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign Busy  = (state != S_IDLE);
  assign Stall = Busy & (Start | HiLoRead);

  // Multiply: {acc_hi,acc_lo} shifts right with multiplier in acc_lo.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd_q} : '0);
    div_sh  = {acc_hi, acc_lo[WIDTH-1]};
    div_sub = div_sh - {1'b0, opd_q};
    div_ge  = ~div_sub[WIDTH];
    prod    = {acc_hi, acc_lo};
    prod_s  = neg_res ? -prod : prod;
    quo     = neg_res ? -acc_lo : acc_lo;
    rem     = neg_rem ? -acc_hi : acc_hi;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      opd_q   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      b_zero  <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      Done    <= 1'b0;
      DivZero <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (Start && (is_mul || is_div)) begin
            op_q    <= Op;
            a_q     <= OperandA;
            opd_q   <= is_mul ? a_mag : b_mag;
            acc_hi  <= '0;
            acc_lo  <= is_mul ? b_mag : a_mag;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (OperandB == '0);
          end else if (Start && Op == 3'b100) begin
            HI <= OperandA;
          end else if (Start && Op == 3'b101) begin
            LO <= OperandA;
          end
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
        end
        S_DIV: begin
          acc_hi <= div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt + CW'(1);
        end
        S_FIX: begin
          Done <= 1'b1;
          cnt  <= '0;
          case (op_q)
            3'b000, 3'b001: {HI, LO} <= prod_s;
            3'b010, 3'b011: begin
              DivZero <= b_zero;
              if (b_zero) begin
                HI <= a_q;
                LO <= '1;
              end else begin
                HI <= rem;
                LO <= quo;
              end
            end
`ifdef HILO_MACC_EN
            3'b110:  {HI, LO} <= {HI, LO} + prod_s;
            3'b111:  {HI, LO} <= {HI, LO} - prod_s;
`endif
            default: ;
          endcase
        end
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Randomized + directed bench for hilo_muldiv_sequencer against a transaction-level HI/LO model.
module tb_hilo_muldiv_sequencer;
  logic        Clk = 1'b0, Rst = 1'b1, Start = 1'b0, HiLoRead = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] OperandA = '0, OperandB = '0;
  logic        Busy, Stall, Done, DivZero;
  logic [31:0] HI, LO;

  hilo_muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OperandA(OperandA),
    .OperandB(OperandB), .HiLoRead(HiLoRead), .Busy(Busy), .Stall(Stall),
    .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;

  // Model: an op occupies the unit for 33 edges, then HI/LO take the arithmetic result.
  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;

  function automatic logic [64:0] calc(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
        return {1'b0, a % b, a / b};
      end
      3'd6: p = {hi, lo} + 64'(sa * sb);
      3'd7: p = {hi, lo} - 64'(sa * sb);
      default: p = '0;
    endcase
    return {1'b0, p};
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      m_cnt = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz;
        end
      end else if (Start) begin
        case (Op)
          3'd4: m_hi = OperandA;
          3'd5: m_lo = OperandA;
          3'd0, 3'd1, 3'd2, 3'd3: begin
            {p_dz, p_hi, p_lo} = calc(Op, OperandA, OperandB, m_hi, m_lo);
            m_cnt = 33;
          end
          default: begin
`ifdef HILO_MACC_EN
            {p_dz, p_hi, p_lo} = calc(Op, OperandA, OperandB, m_hi, m_lo);
            m_cnt = 33;
`endif
          end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: compare registered outputs at negedge, drive inputs, then check Stall.
  task automatic step(input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic rd, input logic rs);
    logic exp_stall;
    @(negedge Clk);
    total++;
    if ({Busy, Done, DivZero, HI, LO} !== {(m_cnt > 0), m_done, m_dz, m_hi, m_lo}) begin
      bad++;
      $display("FAIL cycle t=%0t: busy/done/dz/hi/lo got %b%b%b %h %h expected %b%b%b %h %h",
               $time, Busy, Done, DivZero, HI, LO, (m_cnt > 0), m_done, m_dz, m_hi, m_lo);
    end
    Start = st; Op = op; OperandA = a; OperandB = b; HiLoRead = rd; Rst = rs;
    #1;
    exp_stall = !rs && (m_cnt > 0) && (st || rd);
    total++;
    if (Stall !== exp_stall) begin
      bad++;
      $display("FAIL stall t=%0t: got %b expected %b", $time, Stall, exp_stall);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
  endtask

  // Run until Busy drops; reports cycles Busy was seen and Done/DivZero pulses.
  task automatic run_out(input logic rd, output int busy_cyc, output int done_cnt, output int dz_cnt);
    busy_cyc = 0; done_cnt = 0; dz_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 3'd0, '0, '0, rd, 1'b0);
      done_cnt += int'(Done);
      dz_cnt   += int'(DivZero & Done);
      if (!Busy) return;
      busy_cyc++;
    end
    chk("busy_timeout", 64'(Busy), 64'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    step(1'b1, op, a, b, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_opd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc, dc, zc, sc, mb;
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    chk("reset_hi", 64'(HI), 64'd0);
    chk("reset_lo", 64'(LO), 64'd0);
    chk("reset_busy", 64'(Busy), 64'd0);

    // Reset mid-MULT aborts and clears HI/LO
    issue(3'd5, 32'h55, '0);
    issue(3'd0, 32'd9, 32'd9);
    idle(9);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    idle(30);
    chk("abort_lo", 64'(LO), 64'd0);
    chk("abort_busy", 64'(Busy), 64'd0);

    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    run_out(1'b0, bc, dc, zc);
    chk("multu_hilo", {HI, LO}, 64'h00000001_FFFFFFFE);

    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    run_out(1'b0, bc, dc, zc);
    chk("mult_busy_cycles", 64'(bc), 64'd33);
    chk("mult_done_pulses", 64'(dc), 64'd1);
    chk("mult_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);

    issue(3'd3, 32'd100, 32'd7);
    run_out(1'b0, bc, dc, zc);
    chk("divu_hilo", {HI, LO}, {32'd2, 32'd14});

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    run_out(1'b0, bc, dc, zc);
    chk("div_neg_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_out(1'b0, bc, dc, zc);
    chk("div_ovf_hilo", {HI, LO}, 64'h00000000_80000000);

    issue(3'd2, 32'd5, 32'd0);
    run_out(1'b0, bc, dc, zc);
    chk("div0_hilo", {HI, LO}, {32'd5, 32'hFFFFFFFF});
    chk("div0_dz_with_done", 64'(zc), 64'd1);
    chk("div0_busy_cycles", 64'(bc), 64'd33);

    issue(3'd4, 32'h1234, '0);
    step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
    chk("mthi_hi", 64'(HI), 64'h1234);
    chk("mthi_busy", 64'(Busy), 64'd0);

    // MFHI/MFLO held in EX across a divide
    issue(3'd3, 32'd1000, 32'd3);
    sc = 0;
    for (int i = 0; i < 34; i++) begin
      step(1'b0, 3'd0, '0, '0, 1'b1, 1'b0);
      sc += int'(Stall);
    end
    chk("read_stall_cycles", 64'(sc), 64'd33);
    chk("div_read_hilo", {HI, LO}, {32'd1, 32'd333});

    issue(3'd0, 32'd3, 32'd4);
    idle(4);
    step(1'b1, 3'd1, 32'd9, 32'd9, 1'b0, 1'b0);
    chk("restart_stall", 64'(Stall), 64'd1);
    run_out(1'b0, bc, dc, zc);
    chk("restart_ignored", {HI, LO}, 64'd12);

    issue(3'd4, 32'd0, '0);
    issue(3'd5, 32'd10, '0);
    issue(3'd7, 32'd3, 32'd4);
    mb = 0;
    for (int i = 0; i < 36; i++) begin
      step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
      mb += int'(Busy);
    end
`ifdef HILO_MACC_EN
    chk("msub_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFE);
`else
    chk("msub_illegal_hilo", {HI, LO}, 64'd10);
    chk("msub_illegal_busy", 64'(mb), 64'd0);
`endif

    // Random issue stream with Start noise, reads and occasional resets
    for (int n = 0; n < 40; n++) begin
      int rs_at;
      rs_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : -1;
      issue(3'($urandom_range(0, 7)), rnd_opd(), rnd_opd());
      for (int i = 0; i < 45; i++) begin
        step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
             ($urandom_range(0, 2) == 0), (i == rs_at));
        if (i > rs_at && m_cnt == 0 && !m_done) break;
      end
      idle(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
